// File: rtl/fpu_shift_pkg.sv
// Shared types and constants for the FP alignment right-shifter: FSM states,
// per-stage shift amounts and the stage count.
package fpu_shift_pkg;

    localparam int WIDTH   = 32;
    localparam int STAGES  = 5;
    localparam int STAGE_W = 3;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

    localparam int STAGE_SHAMT [STAGES] = '{16, 8, 4, 2, 1};

    // Out-of-range stage indices map to a zero shift so the mux degrades to a pass-through.
    function automatic int stage_shamt(input logic [STAGE_W-1:0] stage);
        int amt;
        amt = 0;
        case (stage)
            3'd0:    amt = STAGE_SHAMT[0];
            3'd1:    amt = STAGE_SHAMT[1];
            3'd2:    amt = STAGE_SHAMT[2];
            3'd3:    amt = STAGE_SHAMT[3];
            3'd4:    amt = STAGE_SHAMT[4];
            default: amt = 0;
        endcase
        return amt;
    endfunction

endpackage

// File: rtl/rshift_stage_mux.sv
// One stage of the shared right-shifter: shifts by the stage's fixed amount,
// fills vacated MSBs and reports whether any set bit was discarded.
module rshift_stage_mux
    import fpu_shift_pkg::*;
(
    input  logic [WIDTH-1:0]   data,
    input  logic               fill,
    input  logic [STAGE_W-1:0] stage,
    input  logic               enable,
    output logic [WIDTH-1:0]   shifted,
    output logic               dropped
);

    int                 amt_s;
    logic [2*WIDTH-1:0] ext_s;
    logic [2*WIDTH-1:0] mask_s;

    // Shift a fill-extended copy so the vacated MSBs come out as the fill bit.
    always_comb begin
        amt_s  = stage_shamt(stage);
        ext_s  = {{WIDTH{fill}}, data} >> amt_s;
        mask_s = ~({(2*WIDTH){1'b1}} << amt_s);
        if (enable) begin
            shifted = ext_s[WIDTH-1:0];
            dropped = |(data & mask_s[WIDTH-1:0]);
        end else begin
            shifted = data;
            dropped = 1'b0;
        end
    end

endmodule

// File: rtl/fp_align_shift_ctrl.sv
// Multi-cycle mantissa alignment shifter: one 16/8/4/2/1 stage per cycle through
// a single shared mux, with sticky collection and a valid/ready result handshake.
module fp_align_shift_ctrl #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   in_data,
    input  logic [SHAMT_W-1:0] in_shamt,
    input  logic               in_fill,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   out_data,
    output logic               out_sticky,
    output logic               busy
);
    import fpu_shift_pkg::*;

    state_e                state_r;
    logic [STAGE_W-1:0]    stage_r;
    logic [WIDTH-1:0]      data_r;
    logic                  fill_r;
    logic [4:0]            shamt_r;
    logic                  sticky_r;
    logic                  in_ready_r;
    logic                  out_valid_r;
    logic                  busy_r;
    logic [WIDTH-1:0]      out_data_r;
    logic                  out_sticky_r;

    logic                  stage_en_s;
    logic [WIDTH-1:0]      stage_data_s;
    logic                  stage_drop_s;
    logic                  bypass_s;

    assign bypass_s = |in_shamt[SHAMT_W-1:5];

    // Stage 0 handles the 16-bit shift, so stages consume shamt bits MSB first.
    always_comb begin
        stage_en_s = 1'b0;
        case (stage_r)
            3'd0:    stage_en_s = shamt_r[4];
            3'd1:    stage_en_s = shamt_r[3];
            3'd2:    stage_en_s = shamt_r[2];
            3'd3:    stage_en_s = shamt_r[1];
            3'd4:    stage_en_s = shamt_r[0];
            default: stage_en_s = 1'b0;
        endcase
    end

    rshift_stage_mux u_stage_mux (
        .data    (data_r),
        .fill    (fill_r),
        .stage   (stage_r),
        .enable  (stage_en_s),
        .shifted (stage_data_s),
        .dropped (stage_drop_s)
    );

    // Controller FSM; the result registers only load on entry to DONE so they hold otherwise.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= IDLE;
            stage_r      <= 3'd0;
            data_r       <= '0;
            fill_r       <= 1'b0;
            shamt_r      <= 5'd0;
            sticky_r     <= 1'b0;
            in_ready_r   <= 1'b1;
            out_valid_r  <= 1'b0;
            busy_r       <= 1'b0;
            out_data_r   <= '0;
            out_sticky_r <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (in_valid && in_ready_r) begin
                        in_ready_r <= 1'b0;
                        busy_r     <= 1'b1;
                        stage_r    <= 3'd0;
                        fill_r     <= in_fill;
                        shamt_r    <= in_shamt[4:0];
                        sticky_r   <= 1'b0;
                        data_r     <= in_data;
                        if (bypass_s) begin
                            state_r      <= DONE;
                            out_valid_r  <= 1'b1;
                            out_data_r   <= {WIDTH{in_fill}};
                            out_sticky_r <= |in_data;
                        end else begin
                            state_r <= SHIFT;
                        end
                    end else begin
                        in_ready_r <= 1'b1;
                    end
                end
                SHIFT: begin
                    data_r   <= stage_data_s;
                    sticky_r <= sticky_r | stage_drop_s;
                    if (stage_r == 3'(STAGES - 1)) begin
                        state_r      <= DONE;
                        stage_r      <= 3'd0;
                        out_valid_r  <= 1'b1;
                        out_data_r   <= stage_data_s;
                        out_sticky_r <= sticky_r | stage_drop_s;
                    end else begin
                        stage_r <= stage_r + 3'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state_r     <= IDLE;
                        out_valid_r <= 1'b0;
                        in_ready_r  <= 1'b1;
                        busy_r      <= 1'b0;
                    end else begin
                        out_valid_r <= 1'b1;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    stage_r     <= 3'd0;
                    in_ready_r  <= 1'b1;
                    out_valid_r <= 1'b0;
                    busy_r      <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready   = in_ready_r;
    assign out_valid  = out_valid_r;
    assign busy       = busy_r;
    assign out_data   = out_data_r;
    assign out_sticky = out_sticky_r;

endmodule

// File: tb/tb_fp_align_shift_ctrl.sv
// Self-checking bench for fp_align_shift_ctrl: directed corner cases, randomized
// operands against an arithmetic reference model, back-pressure and mid-op reset.
module tb_fp_align_shift_ctrl;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_data;
    logic [7:0]  in_shamt;
    logic        in_fill;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_data;
    logic        out_sticky;
    logic        busy;

    int checks;
    int failures;

    fp_align_shift_ctrl #(.WIDTH(32), .SHAMT_W(8)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .in_shamt   (in_shamt),
        .in_fill    (in_fill),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_data   (out_data),
        .out_sticky (out_sticky),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Returns {sticky, data}: plain arithmetic right shift with fill in the top bits.
    function automatic logic [32:0] ref_model(input logic [31:0] d, input logic [7:0] s, input logic f);
        logic [31:0] r;
        logic [63:0] mask;
        logic        st;
        if (s >= 8'd32) begin
            r  = {32{f}};
            st = |d;
        end else begin
            r = d >> s;
            for (int i = 0; i < 32; i++) begin
                if (i >= 32 - int'(s)) r[i] = f;
            end
            mask = (64'd1 << s) - 64'd1;
            st   = |(d & mask[31:0]);
        end
        return {st, r};
    endfunction

    function automatic int ref_latency(input logic [7:0] s);
        return (s >= 8'd32) ? 0 : 5;
    endfunction

    // Drives one request, scrambles inputs after acceptance, and returns what the DUT delivered.
    // lat counts rising edges after the acceptance edge until out_valid is seen.
    task automatic run_op(input logic [31:0] d, input logic [7:0] s, input logic f, input int hold,
                          output logic [31:0] od, output logic osticky, output int lat, output logic rdy);
        @(negedge clk);
        rdy       = in_ready;
        in_valid  = 1'b1;
        in_data   = d;
        in_shamt  = s;
        in_fill   = f;
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_data  = $urandom;
        in_shamt = 8'($urandom);
        in_fill  = 1'($urandom);
        lat = 0;
        while (!out_valid && lat < 12) begin
            @(posedge clk);
            #1;
            lat++;
            in_data = $urandom;
        end
        od      = out_data;
        osticky = out_sticky;
        repeat (hold) @(posedge clk);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n     = 1'b0;
        in_valid  = 1'b0;
        in_data   = 32'hDEAD_BEEF;
        in_shamt  = 8'd3;
        in_fill   = 1'b1;
        out_ready = 1'b0;
        #22;
        checks++;
        if ({in_ready, out_valid, busy, out_sticky} !== 4'b1000 || out_data !== 32'd0) begin
            failures++;
            $display("FAIL reset_state: got rdy=%b vld=%b busy=%b stk=%b data=%h, want 1 0 0 0 00000000",
                     in_ready, out_valid, busy, out_sticky, out_data);
        end
        in_valid = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (busy !== 1'b0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL reset_hold: got busy=%b vld=%b under reset, want 0 0", busy, out_valid);
        end
        in_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_directed();
        logic [31:0] vd [6];
        logic [7:0]  vs [6];
        logic        vf [6];
        logic [31:0] ed [6];
        logic        es [6];
        int          el [6];
        logic [31:0] od;
        logic        ost;
        int          lat;
        logic        rdy;
        vd = '{32'h8000_0001, 32'hFFFF_FFFF, 32'h0000_00F0, 32'h0000_00F0, 32'h0000_0000, 32'h0000_0010};
        vs = '{8'd1, 8'd31, 8'd4, 8'd0, 8'd40, 8'd40};
        vf = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        ed = '{32'h4000_0000, 32'h0000_0001, 32'hF000_000F, 32'h0000_00F0, 32'h0000_0000, 32'h0000_0000};
        es = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
        el = '{5, 5, 5, 5, 0, 0};
        for (int i = 0; i < 6; i++) begin
            run_op(vd[i], vs[i], vf[i], 0, od, ost, lat, rdy);
            checks++;
            if (rdy !== 1'b1 || od !== ed[i] || ost !== es[i] || lat != el[i]) begin
                failures++;
                $display("FAIL directed_%0d: got rdy=%b data=%h stk=%b lat=%0d, want 1 %h %b %0d",
                         i, rdy, od, ost, lat, ed[i], es[i], el[i]);
            end
        end
    endtask

    task automatic test_random();
        logic [31:0] d;
        logic [7:0]  s;
        logic        f;
        logic [32:0] exp_v;
        logic [31:0] od;
        logic        ost;
        int          lat;
        logic        rdy;
        for (int n = 0; n < 40; n++) begin
            d = $urandom;
            f = 1'($urandom);
            if ($urandom_range(0, 3) == 0) s = 8'($urandom_range(32, 255));
            else                           s = 8'($urandom_range(0, 31));
            exp_v = ref_model(d, s, f);
            run_op(d, s, f, $urandom_range(0, 2), od, ost, lat, rdy);
            checks++;
            if (rdy !== 1'b1 || od !== exp_v[31:0] || ost !== exp_v[32] || lat != ref_latency(s)) begin
                failures++;
                $display("FAIL random_%0d d=%h s=%0d f=%b: got rdy=%b data=%h stk=%b lat=%0d, want 1 %h %b %0d",
                         n, d, s, f, rdy, od, ost, lat, exp_v[31:0], exp_v[32], ref_latency(s));
            end
        end
    endtask

    task automatic test_back_to_back();
        logic [32:0] e1;
        logic [32:0] e2;
        logic [31:0] od;
        logic        ost;
        int          lat;
        logic        rdy;
        e1 = ref_model(32'h1234_5678, 8'd9, 1'b1);
        e2 = ref_model(32'h0F0F_0F0F, 8'd17, 1'b0);
        run_op(32'h1234_5678, 8'd9, 1'b1, 0, od, ost, lat, rdy);
        checks++;
        if (od !== e1[31:0] || ost !== e1[32]) begin
            failures++;
            $display("FAIL b2b_first: got %h/%b, want %h/%b", od, ost, e1[31:0], e1[32]);
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL b2b_ready: got in_ready=%b after handshake, want 1", in_ready);
        end
        in_valid = 1'b1;
        in_data  = 32'h0F0F_0F0F;
        in_shamt = 8'd17;
        in_fill  = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        checks++;
        if (busy !== 1'b1 || in_ready !== 1'b0 || out_valid !== 1'b0 ||
            out_data !== e1[31:0] || out_sticky !== e1[32]) begin
            failures++;
            $display("FAIL b2b_hold_outputs: got busy=%b rdy=%b vld=%b data=%h stk=%b, want 1 0 0 %h %b",
                     busy, in_ready, out_valid, out_data, out_sticky, e1[31:0], e1[32]);
        end
        lat = 0;
        while (!out_valid && lat < 12) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (lat != 5 || out_data !== e2[31:0] || out_sticky !== e2[32]) begin
            failures++;
            $display("FAIL b2b_second: got lat=%0d %h/%b, want 5 %h/%b", lat, out_data, out_sticky, e2[31:0], e2[32]);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        logic [32:0] e;
        int          lat;
        int          stray;
        e = ref_model(32'hA5A5_5A5A, 8'd7, 1'b1);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'hA5A5_5A5A;
        in_shamt = 8'd7;
        in_fill  = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        lat = 0;
        while (!out_valid && lat < 12) begin
            @(posedge clk);
            #1;
            lat++;
        end
        checks++;
        if (lat != 5) begin
            failures++;
            $display("FAIL bp_latency: got %0d, want 5", lat);
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = 32'h0000_0001;
            in_shamt = 8'd1;
            in_fill  = 1'b0;
            checks++;
            if (in_ready !== 1'b0 || out_valid !== 1'b1 || busy !== 1'b1 ||
                out_data !== e[31:0] || out_sticky !== e[32]) begin
                failures++;
                $display("FAIL bp_stall_%0d: got rdy=%b vld=%b busy=%b data=%h stk=%b, want 0 1 1 %h %b",
                         c, in_ready, out_valid, busy, out_data, out_sticky, e[31:0], e[32]);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        in_valid  = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || busy !== 1'b0) begin
            failures++;
            $display("FAIL bp_release: got vld=%b rdy=%b busy=%b, want 0 1 0", out_valid, in_ready, busy);
        end
        stray = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (out_valid || busy) stray++;
        end
        checks++;
        if (stray != 0) begin
            failures++;
            $display("FAIL bp_no_second_accept: got %0d busy/valid cycles, want 0", stray);
        end
    endtask

    task automatic test_reset_mid();
        logic [32:0] e;
        logic [31:0] od;
        logic        ost;
        int          lat;
        logic        rdy;
        int          stray;
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'hFFFF_0000;
        in_shamt = 8'd13;
        in_fill  = 1'b0;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        checks++;
        if ({in_ready, out_valid, busy, out_sticky} !== 4'b1000 || out_data !== 32'd0) begin
            failures++;
            $display("FAIL midreset_state: got rdy=%b vld=%b busy=%b stk=%b data=%h, want 1 0 0 0 00000000",
                     in_ready, out_valid, busy, out_sticky, out_data);
        end
        @(negedge clk);
        rst_n = 1'b1;
        stray = 0;
        for (int c = 0; c < 8; c++) begin
            @(posedge clk);
            #1;
            if (out_valid || busy) stray++;
        end
        checks++;
        if (stray != 0) begin
            failures++;
            $display("FAIL midreset_no_result: got %0d busy/valid cycles, want 0", stray);
        end
        e = ref_model(32'h8765_4321, 8'd22, 1'b1);
        run_op(32'h8765_4321, 8'd22, 1'b1, 1, od, ost, lat, rdy);
        checks++;
        if (rdy !== 1'b1 || od !== e[31:0] || ost !== e[32] || lat != 5) begin
            failures++;
            $display("FAIL midreset_recover: got rdy=%b %h/%b lat=%0d, want 1 %h/%b 5",
                     rdy, od, ost, lat, e[31:0], e[32]);
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        test_reset();
        test_directed();
        test_random();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
